// File: rtl/inst_mem_responder_pkg.sv
// inst_mem_responder_pkg: shared types and constants for the instruction-fetch responder
package inst_mem_responder_pkg;
  typedef enum logic {IDLE, WAIT} state_e;
  localparam int INST_BYTES = 4;
  localparam int WORD_SHIFT = 2;
  // Canonical RISC-V NOP (addi x0,x0,0), used by IF/ID when squashing on flush
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/inst_mem_array.sv
// inst_mem_array: DEPTH x INST_W instruction store, synchronous write, asynchronous read
module inst_mem_array #(
  parameter int INST_W = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [INST_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [INST_W-1:0] o_rdata
);
  logic [INST_W-1:0] mem_q [DEPTH];
  always_ff @(posedge i_clk) if (i_we) mem_q[i_waddr] <= i_wdata;
  assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: accepts a PC fetch request, waits LATENCY edges, returns one instruction word
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int INST_W  = 32,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [INST_W-1:0] i_wdata,
  output logic [INST_W-1:0] o_inst,
  output logic              o_valid,
  output logic              o_err,
  output logic              o_busy,
  output logic              o_drop
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-WORD_SHIFT-1:0] DEPTH_IX = (ADDR_W-WORD_SHIFT)'(DEPTH);
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              err_q, err_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d, oerr_q, oerr_d, drop_q, drop_d;
  logic [INST_W-1:0] rdata;
  logic              accept;
  inst_mem_array #(.INST_W(INST_W), .DEPTH(DEPTH)) u_mem (
    .i_clk  (i_clk),
    .i_we   (i_we),
    .i_waddr(i_waddr),
    .i_wdata(i_wdata),
    .i_raddr(idx_q),
    .o_rdata(rdata)
  );
  // A flush frees the slot on the same edge, so a coincident request is taken
  assign accept = i_valid && (state_q == IDLE || i_flush);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    inst_d  = inst_q;
    valid_d = 1'b0;
    oerr_d  = 1'b0;
    drop_d  = 1'b0;
    if (accept) begin
      state_d = WAIT;
      cnt_d   = CW'(LATENCY - 1);
      idx_d   = i_addr[AW+WORD_SHIFT-1:WORD_SHIFT];
      err_d   = (i_addr[WORD_SHIFT-1:0] != '0) || (i_addr[ADDR_W-1:WORD_SHIFT] >= DEPTH_IX);
    end else if (state_q == WAIT && i_flush) begin
      state_d = IDLE;
    end else if (state_q == WAIT) begin
      drop_d = i_valid;
      cnt_d  = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      if (cnt_q == '0) begin
        state_d = IDLE;
        valid_d = 1'b1;
        oerr_d  = err_q;
        inst_d  = err_q ? '0 : rdata;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      oerr_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      oerr_q  <= oerr_d;
      drop_q  <= drop_d;
    end
  end
  assign o_inst  = inst_q;
  assign o_valid = valid_q;
  assign o_err   = oerr_q;
  assign o_drop  = drop_q;
  assign o_busy  = (state_q == WAIT);
endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Responder end of the PC → instruction-fetch interface.
- Accepts a valid instruction-address request from the PC stage, waits a fixed, parameterised access latency, then returns one instruction word with a one-cycle valid pulse.
- Holds the instruction store and a preload write port used by the bench and boot loader.
- Sits between the PC stage and the IF/ID pipeline register.

Parameters:
- INST_W, 32, instruction word width.
- ADDR_W, 64, byte-address width.
- DEPTH, 1024, number of instruction words in the store (power of 2).
- LATENCY, 4, edges from request accept to response valid. Must be at least 1. The default fits the PC's 5-cycle issue cadence.

Ports:
- i_clk  in  1  clock, rising-edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  request strobe from the PC stage.
- i_addr  in  ADDR_W  byte address of the requested instruction.
- i_flush  in  1  abort the outstanding request (branch/redirect).
- i_we  in  1  preload write enable.
- i_waddr  in  log2(DEPTH)  preload word index.
- i_wdata  in  INST_W  preload data.
- o_inst  out  INST_W  returned instruction.
- o_valid  out  1  one-cycle pulse: o_inst and o_err are valid.
- o_err  out  1  qualifies o_valid: request was misaligned or out of range.
- o_busy  out  1  request outstanding; new requests are not accepted.
- o_drop  out  1  one-cycle pulse: a request arrived while busy and was discarded.

Behaviour:
- Reset (async, i_rst_n low):
  - State goes to IDLE; counter 0.
  - o_inst=0, o_valid=0, o_err=0, o_drop=0.
  - Storage array is not reset.
  - Reset mid-request discards the request with no response.
- FSM states: IDLE, WAIT.
  - o_busy = (state==WAIT), combinational.
- IDLE:
  - When i_valid is sampled high: latch word index i_addr[ADDR_W-1:2].
  - Latch err = (i_addr[1:0]!=0) or (i_addr[ADDR_W-1:2] >= DEPTH).
  - Load cnt=LATENCY-1 and go to WAIT.
- WAIT:
  - Each edge with cnt!=0: cnt decrements.
  - Edge with cnt==0: register o_inst = err ? 0 : mem[index]; o_err=err; o_valid=1 for exactly one cycle; state goes to IDLE.
  - Response rises LATENCY edges after the accept edge.
- Back-to-back:
  - In the o_valid cycle the state is already IDLE and o_busy=0.
  - An i_valid sampled there is accepted, so the sustained period is LATENCY+1 cycles per request.
- i_valid while WAIT: request ignored; o_drop pulses for one cycle; the outstanding request is unaffected.
- i_flush:
  - While WAIT: state goes to IDLE; no o_valid for the aborted request, including when cnt==0 on that same edge.
  - Flush and i_valid on the same edge: the old request is aborted and the new one accepted (cnt reloaded); o_drop stays 0.
  - Flush while IDLE has no effect.
- o_valid, o_err and o_drop are 0 in every cycle not listed above. o_inst holds its last value.
- Preload write: mem[i_waddr] <= i_wdata on the rising edge, at any time.
  - The response read on an edge sees the array contents before that edge's write (read-before-write).
  - A write during WAIT to the pending index is visible if it lands on an earlier edge.
- Width rules:
  - Index comparison against DEPTH uses the full ADDR_W-2 index, so upper address bits are not truncated.
  - The counter width is clog2(LATENCY), minimum 1.

Decomposition:
- Shared package:
  - state enum (IDLE, WAIT).
  - INST_BYTES=4.
  - WORD_SHIFT=2.
  - NOP constant, reserved for flush fill by the IF/ID register.
- One sub-module: inst_mem_array.
  - DEPTH x INST_W storage.
  - Synchronous write port, asynchronous read port.
  - Instantiated by inst_mem_responder.

Test Plan:
- Preload mem[3]=32'h00A00093; request i_addr=64'h0C with LATENCY=4 → o_busy for 4 cycles, o_valid pulse 4 edges after accept with o_inst=32'h00A00093, o_err=0.
- Request i_addr=64'h0E (misaligned), then i_addr=64'h1000 with DEPTH=1024 → each gives o_valid with o_err=1 and o_inst=0.
- Second i_valid 2 cycles after accept → o_drop pulses once; the first response is unchanged. Then i_valid in the o_valid cycle → accepted, with the next o_valid 4 edges later.
- i_flush on the edge where cnt==0 → no o_valid. Flush plus i_valid at i_addr=64'h10 on the same edge → single response with mem[4], 4 edges later.
- mem[5]=32'h1 pending; write mem[5]=32'h2 two edges after accept → response 32'h2. A write on the response edge itself → old value 32'h1 is returned.
- Assert i_rst_n low mid-WAIT → all outputs 0 immediately, no response. After release, a fresh request completes normally.
